// File: rtl/counter_sequencer_pkg.sv
// Shared encodings for the counter run-control sequencer.
package counter_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic MODE_ONESHOT  = 1'b0;
    localparam logic MODE_PERIODIC = 1'b1;

endpackage

// File: rtl/counter_datapath.sv
// WIDTH-bit adder + register; synchronous clear wins over enable.
module counter_datapath #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RESETN,
    input  logic             CLR,
    input  logic             EN,
    output logic [WIDTH-1:0] O,
    output logic             COUT
);

    logic [WIDTH-1:0] o_q, o_d;
    logic [WIDTH:0]   sum_ext;

    assign sum_ext = {1'b0, o_q} + {{WIDTH{1'b0}}, 1'b1};

    always_comb begin
        o_d = o_q;
        if (CLR)
            o_d = '0;
        else if (EN)
            o_d = sum_ext[WIDTH-1:0];
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN)
            o_q <= '0;
        else
            o_q <= o_d;
    end

    assign O    = o_q;
    assign COUT = sum_ext[WIDTH];

endmodule

// File: rtl/counter_sequencer.sv
// Start/stop, terminal count and one-shot/periodic control around counter_datapath.
module counter_sequencer
    import counter_sequencer_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RESETN,
    input  logic             START,
    input  logic             STOP,
    input  logic             MODE,
    input  logic [WIDTH-1:0] PERIOD,
    output logic [WIDTH-1:0] COUNT,
    output logic             BUSY,
    output logic             TC,
    output logic             DONE
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] period_q, period_d;
    logic             mode_q, mode_d;
    logic             cnt_clr, cnt_en;
    logic             tc_hit;
    logic             go;
    logic             cout_unused;

    counter_datapath #(.WIDTH(WIDTH)) u_dp (
        .CLK    (CLK),
        .RESETN (RESETN),
        .CLR    (cnt_clr),
        .EN     (cnt_en),
        .O      (COUNT),
        .COUT   (cout_unused)
    );

    assign go     = START & ~STOP;
    assign tc_hit = (state_q == ST_RUN) && (COUNT == period_q);

    always_comb begin
        state_d  = state_q;
        period_d = period_q;
        mode_d   = mode_q;
        cnt_clr  = 1'b0;
        cnt_en   = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                cnt_clr = 1'b1;
                state_d = ST_IDLE;
                if (go) begin
                    state_d  = ST_RUN;
                    period_d = PERIOD;
                    mode_d   = MODE;
                end
            end
            ST_RUN: begin
                if (STOP) begin
                    cnt_clr = 1'b1;
                    state_d = ST_IDLE;
                end else if (tc_hit) begin
                    // compare forces zero, so the adder never wraps
                    cnt_clr = 1'b1;
                    state_d = (mode_q == MODE_PERIODIC) ? ST_RUN : ST_DONE;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            default: begin
                cnt_clr = 1'b1;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state_q  <= ST_IDLE;
            period_q <= '0;
            mode_q   <= MODE_ONESHOT;
        end else begin
            state_q  <= state_d;
            period_q <= period_d;
            mode_q   <= mode_d;
        end
    end

    assign BUSY = (state_q == ST_RUN);
    assign TC   = tc_hit & ~STOP;
    assign DONE = (state_q == ST_DONE);

endmodule
